meas_ctrl: RTL and testbench

Sequencer for the ring-oscillator PUF measurement datapath. For each of `C_OIDWIDTH` ID bits it:
- fetches a challenge pair of oscillator selectors from challenge memory;
- clears the oscillator counters and opens a fixed gate window;
- samples the comparator result and shifts it into the primitive ID.

It sits between the challenge memory and the oscillator counter / mux / comparator datapath, and exposes a start/done handshake to the system.

---
 rtl/meas_ctrl_pkg.sv | 20 ++
 rtl/meas_ctrl_if.sv | 32 +++
 rtl/meas_ctrl_tmr.sv | 26 ++
 rtl/meas_ctrl.sv | 130 +++++++++++++
 tb/tb_meas_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/meas_ctrl_pkg.sv
// meas_pkg: shared state encoding, default phase lengths and counter sizing for meas_ctrl
package meas_pkg;
  typedef enum logic [3:0] {
    S_IDLE,
    S_RD,
    S_LD1,
    S_LD2,
    S_CLR,
    S_GATE,
    S_SETTLE,
    S_CAPT,
    S_DONE
  } meas_ctrl_state_t;
  localparam int DEF_CLRCYC    = 2;
  localparam int DEF_GATECYC   = 1024;
  localparam int DEF_SETTLECYC = 2;
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/meas_ctrl_if.sv
// meas_ctrl_if: start/done handshake, challenge memory port and oscillator datapath controls
interface meas_ctrl_if #(
  parameter int C_SELWIDTH     = 8,
  parameter int C_OIDWIDTH     = 24,
  parameter int C_MEMDATAWIDTH = 8,
  parameter int C_MEMADDRWIDTH = 24
);
  logic                      I_start;
  logic                      O_busy;
  logic                      O_done;
  logic [C_MEMADDRWIDTH-1:0] O_mem_addr;
  logic                      O_mem_rd;
  logic [C_MEMDATAWIDTH-1:0] I_mem_data;
  logic [C_SELWIDTH-1:0]     O_sel_1;
  logic [C_SELWIDTH-1:0]     O_sel_2;
  logic                      O_osc_rst;
  logic                      O_osc_en;
  logic                      I_comp;
  logic [C_OIDWIDTH-1:0]     O_prim_id;
  logic                      O_id_valid;
  logic                      O_err;
  modport master (
    input  I_start, I_mem_data, I_comp,
    output O_busy, O_done, O_mem_addr, O_mem_rd, O_sel_1, O_sel_2,
           O_osc_rst, O_osc_en, O_prim_id, O_id_valid, O_err
  );
  modport slave (
    output I_start, I_mem_data, I_comp,
    input  O_busy, O_done, O_mem_addr, O_mem_rd, O_sel_1, O_sel_2,
           O_osc_rst, O_osc_en, O_prim_id, O_id_valid, O_err
  );
endinterface

// File: rtl/meas_ctrl_tmr.sv
// meas_ctrl_tmr: loadable down-counter; O_exp pulses in the last cycle of a loaded phase
module meas_ctrl_tmr #(
  parameter int W = 11
) (
  input  logic         I_sclk,
  input  logic         I_rst,
  input  logic         I_load,
  input  logic [W-1:0] I_val,
  output logic         O_exp
);
  logic [W-1:0] r_cnt;
  logic         r_run;
  assign O_exp = r_run && r_cnt == '0;
  always_ff @(posedge I_sclk) begin
    if (I_rst) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (I_load) begin
      r_cnt <= I_val;
      r_run <= 1'b1;
    end else if (r_run) begin
      r_cnt <= r_cnt - 1'b1;
      r_run <= r_cnt != '0;
    end
  end
endmodule

// File: rtl/meas_ctrl.sv
// meas_ctrl: RO-PUF measurement sequencer (challenge fetch, count gating, ID shift-in).
// Define MEAS_CTRL_SELCHK_EN to reject out-of-range or identical selector pairs via O_err.
module meas_ctrl
  import meas_pkg::*;
#(
  parameter int C_IOSCNUM      = 48,
  parameter int C_SELWIDTH     = 8,
  parameter int C_OIDWIDTH     = 24,
  parameter int C_MEMDATAWIDTH = 8,
  parameter int C_MEMADDRWIDTH = 24,
  parameter int C_MEMSTADDR    = 0,
  parameter int C_CLRCYC       = DEF_CLRCYC,
  parameter int C_GATECYC      = DEF_GATECYC,
  parameter int C_SETTLECYC    = DEF_SETTLECYC
) (
  input logic         I_sclk,
  input logic         I_rst,
  meas_ctrl_if.master bus
);
  localparam int CW = cnt_width(C_OIDWIDTH);
  localparam int TW = cnt_width(C_CLRCYC + C_GATECYC + C_SETTLECYC);
  meas_ctrl_state_t          r_state, w_next;
  logic [C_MEMADDRWIDTH-1:0] r_addr;
  logic [C_SELWIDTH-1:0]     r_sel1, r_sel2, w_data;
  logic [C_OIDWIDTH-1:0]     r_id;
  logic [CW-1:0]             r_cnt, w_cnt_inc;
  logic [TW-1:0]             w_tval;
  logic r_busy, r_done, r_rd, r_osc_rst, r_osc_en, r_valid, r_err;
  logic w_exp, w_load, w_bad, w_last;

  assign w_data    = C_SELWIDTH'(bus.I_mem_data);
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_last    = w_cnt_inc == CW'(C_OIDWIDTH);
`ifdef MEAS_CTRL_SELCHK_EN
  assign w_bad = 32'(r_sel1) >= 32'(C_IOSCNUM) || 32'(w_data) >= 32'(C_IOSCNUM) || r_sel1 == w_data;
`else
  assign w_bad = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = bus.I_start ? S_RD : S_IDLE;
      S_RD:     w_next = S_LD1;
      S_LD1:    w_next = S_LD2;
      S_LD2:    w_next = w_bad ? S_DONE : S_CLR;
      S_CLR:    w_next = w_exp ? S_GATE : S_CLR;
      S_GATE:   w_next = w_exp ? S_SETTLE : S_GATE;
      S_SETTLE: w_next = w_exp ? S_CAPT : S_SETTLE;
      S_CAPT:   w_next = w_last ? S_DONE : S_RD;
      default:  w_next = S_IDLE;
    endcase
  end

  // one timer serves all three timed phases; it is reloaded on each phase entry
  assign w_load = w_next != r_state && (w_next == S_CLR || w_next == S_GATE || w_next == S_SETTLE);
  assign w_tval = w_next == S_CLR  ? TW'(C_CLRCYC - 1) :
                  w_next == S_GATE ? TW'(C_GATECYC - 1) : TW'(C_SETTLECYC - 1);

  meas_ctrl_tmr #(.W(TW)) u_tmr (
    .I_sclk (I_sclk),
    .I_rst  (I_rst),
    .I_load (w_load),
    .I_val  (w_tval),
    .O_exp  (w_exp)
  );

  // outputs are decoded from the next state so they line up with the state they belong to
  always_ff @(posedge I_sclk) begin
    if (I_rst) begin
      r_state   <= S_IDLE;
      r_addr    <= C_MEMADDRWIDTH'(C_MEMSTADDR);
      r_sel1    <= '0;
      r_sel2    <= '0;
      r_id      <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd      <= 1'b0;
      r_osc_rst <= 1'b1;
      r_osc_en  <= 1'b0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_busy    <= w_next != S_IDLE;
      r_rd      <= w_next == S_RD || w_next == S_LD1;
      r_osc_rst <= w_next == S_IDLE || w_next == S_CLR;
      r_osc_en  <= w_next == S_GATE;
      r_done    <= r_state == S_DONE;
      case (r_state)
        S_IDLE:
          if (bus.I_start) begin
            r_addr  <= C_MEMADDRWIDTH'(C_MEMSTADDR);
            r_cnt   <= '0;
            r_id    <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
          end
        S_RD:  r_addr <= r_addr + 1'b1;
        S_LD1: begin
          r_sel1 <= w_data;
          r_addr <= r_addr + 1'b1;
        end
        S_LD2: begin
          r_sel2 <= w_data;
          r_err  <= w_bad;
        end
        S_CAPT: begin
          r_id  <= {r_id[C_OIDWIDTH-2:0], bus.I_comp};
          r_cnt <= w_cnt_inc;
        end
        S_DONE: r_valid <= !r_err;
        default: ;
      endcase
    end
  end

  assign bus.O_busy     = r_busy;
  assign bus.O_done     = r_done;
  assign bus.O_mem_addr = r_addr;
  assign bus.O_mem_rd   = r_rd;
  assign bus.O_sel_1    = r_sel1;
  assign bus.O_sel_2    = r_sel2;
  assign bus.O_osc_rst  = r_osc_rst;
  assign bus.O_osc_en   = r_osc_en;
  assign bus.O_prim_id  = r_id;
  assign bus.O_id_valid = r_valid;
  assign bus.O_err      = r_err;
endmodule

// File: tb/tb_meas_ctrl.sv
// tb_meas_ctrl: directed bench for meas_ctrl at default size plus a small wrap-around instance
module tb_meas_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;

  meas_ctrl_if bus ();
  meas_ctrl_if #(.C_OIDWIDTH(4), .C_MEMADDRWIDTH(4)) bus_b ();

  meas_ctrl dut (.I_sclk(clk), .I_rst(rst), .bus(bus));
  meas_ctrl #(.C_OIDWIDTH(4), .C_MEMADDRWIDTH(4), .C_MEMSTADDR(14), .C_GATECYC(4)) dut_b (
    .I_sclk(clk), .I_rst(rst), .bus(bus_b));

  logic [7:0] mem_a [64];
  logic [7:0] mem_b [16];
  always @(posedge clk) if (bus.O_mem_rd) bus.I_mem_data <= mem_a[bus.O_mem_addr[5:0]];
  always @(posedge clk) if (bus_b.O_mem_rd) bus_b.I_mem_data <= mem_b[bus_b.O_mem_addr];

  // protocol monitor for the default instance; also plays the comparator from pat
  logic [23:0] pat = 24'h0;
  int gates = 0, en_run = 0, rst_run = 0, rst_len = 0;
  int gate_err = 0, clr_err = 0, ov_err = 0, sel_err = 0, done_cnt = 0;
  logic [23:0] rd_q [$];
  logic [3:0] rd_qb [$];
  logic p1_rd = 1'b0, p2_rd = 1'b0, chk2 = 1'b0;
  logic [23:0] p1_addr = '0, p2_addr = '0, chk2_addr = '0;
  always @(negedge clk) begin
    if (bus.I_start && !bus.O_busy) begin
      gates = 0; en_run = 0; rst_run = 0; rst_len = 0;
      gate_err = 0; clr_err = 0; ov_err = 0; sel_err = 0; done_cnt = 0;
      p1_rd = 1'b0; p2_rd = 1'b0; chk2 = 1'b0;
      rd_q.delete();
    end else begin
      if (bus.O_done) done_cnt++;
      if (bus.O_osc_en && bus.O_osc_rst) ov_err++;
      if (bus.O_osc_rst) rst_run++;
      else if (rst_run > 0) begin rst_len = rst_run; rst_run = 0; end
      if (bus.O_osc_en) begin
        if (en_run == 0 && rst_len != 2) clr_err++;
        en_run++;
      end else if (en_run > 0) begin
        if (en_run != 1024) gate_err++;
        gates++;
        en_run = 0;
      end
      if (chk2 && bus.O_sel_2 !== mem_a[chk2_addr[5:0]]) sel_err++;
      chk2 = 1'b0;
      if (!bus.O_mem_rd && p1_rd && p2_rd) begin
        if (bus.O_sel_1 !== mem_a[p2_addr[5:0]]) sel_err++;
        chk2 = 1'b1;
        chk2_addr = p1_addr;
      end
      if (bus.O_mem_rd) rd_q.push_back(bus.O_mem_addr);
      p2_rd = p1_rd; p2_addr = p1_addr;
      p1_rd = bus.O_mem_rd; p1_addr = bus.O_mem_addr;
    end
    bus.I_comp = (gates > 0 && gates <= 24) ? pat[24 - gates] : 1'b0;
  end

  always @(negedge clk) begin
    if (bus_b.I_start && !bus_b.O_busy) rd_qb.delete();
    else if (bus_b.O_mem_rd) rd_qb.push_back(bus_b.O_mem_addr);
  end

  task automatic run_a(input int bound, output int n);
    @(posedge clk); #1 bus.I_start = 1'b1;
    @(posedge clk); #1 bus.I_start = 1'b0;
    n = 0;
    while (bus.O_done !== 1'b1 && n < bound) begin @(posedge clk); #1; n++; end
  endtask

  task automatic test_reset();
    bus.I_start = 1'b0;
    bus_b.I_start = 1'b0;
    bus_b.I_comp = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.O_busy, bus.O_done, bus.O_mem_rd, bus.O_osc_en, bus.O_osc_rst, bus.O_id_valid, bus.O_err} !== 7'b0000100) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000100", {bus.O_busy, bus.O_done, bus.O_mem_rd, bus.O_osc_en, bus.O_osc_rst, bus.O_id_valid, bus.O_err});
    end
    checks++;
    if (bus.O_mem_addr !== 24'd0) begin errors++; $display("FAIL reset_addr: got %0h want 0", bus.O_mem_addr); end
    checks++;
    if ({bus.O_sel_1, bus.O_sel_2} !== 16'h0) begin errors++; $display("FAIL reset_sel: got %h want 0000", {bus.O_sel_1, bus.O_sel_2}); end
    checks++;
    if (bus.O_prim_id !== 24'h0) begin errors++; $display("FAIL reset_id: got %h want 000000", bus.O_prim_id); end
    checks++;
    if (bus_b.O_mem_addr !== 4'd14) begin errors++; $display("FAIL reset_addr_b: got %0d want 14", bus_b.O_mem_addr); end
    rst = 1'b0;
  endtask

  task automatic test_basic_run();
    int n, bad;
    for (int i = 0; i < 64; i++) mem_a[i] = 8'(i);
    pat = 24'hAAAAAA;
    run_a(30000, n);
    checks++;
    if (n !== 24769) begin errors++; $display("FAIL run_latency: got %0d want 24769", n); end
    checks++;
    if (bus.O_prim_id !== 24'hAAAAAA) begin errors++; $display("FAIL basic_id: got %h want aaaaaa", bus.O_prim_id); end
    checks++;
    if ({bus.O_id_valid, bus.O_busy, bus.O_err} !== 3'b100) begin
      errors++; $display("FAIL basic_flags: got %b want 100", {bus.O_id_valid, bus.O_busy, bus.O_err});
    end
    checks++;
    if (gates !== 24 || gate_err !== 0) begin errors++; $display("FAIL gate_window: gates %0d bad %0d want 24 0", gates, gate_err); end
    checks++;
    if (clr_err !== 0 || ov_err !== 0) begin errors++; $display("FAIL clr_phase: clr %0d overlap %0d want 0 0", clr_err, ov_err); end
    bad = 0;
    foreach (rd_q[i]) if (rd_q[i] !== 24'(i)) bad++;
    checks++;
    if (rd_q.size() !== 48 || bad !== 0) begin errors++; $display("FAIL mem_addr_seq: reads %0d bad %0d want 48 0", rd_q.size(), bad); end
    checks++;
    if (sel_err !== 0) begin errors++; $display("FAIL sel_latch: got %0d bad latches want 0", sel_err); end
    checks++;
    if (bus.O_mem_addr !== 24'd48) begin errors++; $display("FAIL final_addr: got %0d want 48", bus.O_mem_addr); end
    @(posedge clk); #1;
    checks++;
    if ({bus.O_done, bus.O_id_valid} !== 2'b01) begin errors++; $display("FAIL done_pulse: got %b want 01", {bus.O_done, bus.O_id_valid}); end
  endtask

  task automatic test_reset_mid_gate();
    int n;
    @(posedge clk); #1 bus.I_start = 1'b1;
    @(posedge clk); #1 bus.I_start = 1'b0;
    n = 0;
    while (!(gates == 5 && bus.O_osc_en) && n < 10000) begin @(posedge clk); #1; n++; end
    checks++;
    if (gates !== 5 || bus.O_osc_en !== 1'b1) begin errors++; $display("FAIL reach_bit5: gates %0d en %b want 5 1", gates, bus.O_osc_en); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.O_busy, bus.O_done, bus.O_mem_rd, bus.O_osc_en, bus.O_osc_rst, bus.O_id_valid, bus.O_err} !== 7'b0000100
        || bus.O_mem_addr !== 24'd0 || {bus.O_sel_1, bus.O_sel_2} !== 16'h0 || bus.O_prim_id !== 24'h0) begin
      errors++;
      $display("FAIL mid_reset_state: flags %b addr %0h sel %h id %h want 0000100 0 0000 000000",
               {bus.O_busy, bus.O_done, bus.O_mem_rd, bus.O_osc_en, bus.O_osc_rst, bus.O_id_valid, bus.O_err},
               bus.O_mem_addr, {bus.O_sel_1, bus.O_sel_2}, bus.O_prim_id);
    end
    rst = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    checks++;
    if (done_cnt !== 0 || bus.O_busy !== 1'b0) begin errors++; $display("FAIL no_done_after_rst: done %0d busy %b want 0 0", done_cnt, bus.O_busy); end
    mem_a[6] = 8'd48;
    mem_a[7] = 8'd2;
    pat = 24'h5A3C96;
    run_a(30000, n);
`ifdef MEAS_CTRL_SELCHK_EN
    checks++;
    if (n !== 3100) begin errors++; $display("FAIL selchk_latency: got %0d want 3100", n); end
    checks++;
    if ({bus.O_err, bus.O_id_valid} !== 2'b10) begin errors++; $display("FAIL selchk_flags: got %b want 10", {bus.O_err, bus.O_id_valid}); end
    checks++;
    if (bus.O_prim_id !== 24'h000002) begin errors++; $display("FAIL selchk_partial_id: got %h want 000002", bus.O_prim_id); end
`else
    checks++;
    if (n !== 24769) begin errors++; $display("FAIL rerun_latency: got %0d want 24769", n); end
    checks++;
    if ({bus.O_err, bus.O_id_valid} !== 2'b01) begin errors++; $display("FAIL rerun_flags: got %b want 01", {bus.O_err, bus.O_id_valid}); end
    checks++;
    if (bus.O_prim_id !== 24'h5A3C96) begin errors++; $display("FAIL rerun_id: got %h want 5a3c96", bus.O_prim_id); end
    checks++;
    if (gates !== 24 || gate_err !== 0 || sel_err !== 0) begin
      errors++; $display("FAIL rerun_phases: gates %0d gerr %0d serr %0d want 24 0 0", gates, gate_err, sel_err);
    end
`endif
    mem_a[6] = 8'd6;
    mem_a[7] = 8'd7;
  endtask

  task automatic test_addr_wrap();
    int n, bad;
    logic [3:0] exp_addr [8] = '{4'd14, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    for (int i = 0; i < 16; i++) mem_b[i] = 8'(i);
    @(posedge clk); #1 bus_b.I_start = 1'b1;
    @(posedge clk); #1 bus_b.I_start = 1'b0;
    n = 0;
    while (bus_b.O_done !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (n !== 49) begin errors++; $display("FAIL wrap_latency: got %0d want 49", n); end
    bad = 0;
    foreach (rd_qb[i]) if (i < 8 && rd_qb[i] !== exp_addr[i]) bad++;
    checks++;
    if (rd_qb.size() !== 8 || bad !== 0) begin errors++; $display("FAIL wrap_addr_seq: reads %0d bad %0d want 8 0", rd_qb.size(), bad); end
    checks++;
    if (bus_b.O_mem_addr !== 4'd6) begin errors++; $display("FAIL wrap_final_addr: got %0d want 6", bus_b.O_mem_addr); end
    checks++;
    if ({bus_b.O_sel_1, bus_b.O_sel_2} !== 16'h0405) begin errors++; $display("FAIL wrap_last_sel: got %h want 0405", {bus_b.O_sel_1, bus_b.O_sel_2}); end
    checks++;
    if ({bus_b.O_id_valid, bus_b.O_prim_id} !== 5'h1F) begin errors++; $display("FAIL wrap_id: got %h want 1f", {bus_b.O_id_valid, bus_b.O_prim_id}); end
  endtask

  task automatic test_back_to_back();
    int n;
    @(posedge clk); #1 bus_b.I_start = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (bus_b.O_done !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (n !== 49 || bus_b.O_busy !== 1'b0) begin errors++; $display("FAIL held_start_run: cycles %0d busy %b want 49 0", n, bus_b.O_busy); end
    @(posedge clk); #1 bus_b.I_start = 1'b0;
    checks++;
    if ({bus_b.O_busy, bus_b.O_done, bus_b.O_id_valid, bus_b.O_mem_rd} !== 4'b1001 || bus_b.O_mem_addr !== 4'd14) begin
      errors++;
      $display("FAIL restart_after_done: flags %b addr %0d want 1001 14", {bus_b.O_busy, bus_b.O_done, bus_b.O_id_valid, bus_b.O_mem_rd}, bus_b.O_mem_addr);
    end
    n = 0;
    while (bus_b.O_done !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (n !== 49 || {bus_b.O_id_valid, bus_b.O_prim_id} !== 5'h1F) begin
      errors++; $display("FAIL second_run: cycles %0d id %h want 49 1f", n, {bus_b.O_id_valid, bus_b.O_prim_id});
    end
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_reset_mid_gate();
    test_addr_wrap();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
